// File: rtl/acs_pm_array64.sv
// Add-compare-select stage of a K=7 rate-1/2 hard-decision Viterbi decoder:
// 64 registered path metrics, one survivor-decision word per accepted symbol pair.
module acs_pm_array64 #(
    parameter int         PM_W    = 8,
    parameter int         INIT_PM = 64,
    parameter logic [6:0] G0      = 7'o171,
    parameter logic [6:0] G1      = 7'o133
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sof,
    input  logic [1:0]      rx_pair,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [63:0]     dec_bits,
    output logic [5:0]      best_state,
    output logic [PM_W-1:0] best_pm,
    output logic            norm_pulse
);

    localparam logic [PM_W-1:0] INIT_PM_V = PM_W'(INIT_PM);
    localparam logic [PM_W-1:0] ZERO_PM_V = {PM_W{1'b0}};

    // Hamming distance between the received pair and the branch's expected symbols {c0,c1}.
    function automatic logic [1:0] branch_metric(input logic [6:0] r, input logic [1:0] rx);
        logic c0;
        logic c1;
        c0 = ^(r & G0);
        c1 = ^(r & G1);
        return {1'b0, rx[1] ^ c0} + {1'b0, rx[0] ^ c1};
    endfunction

    logic [PM_W-1:0] pm_r      [64];
    logic [PM_W-1:0] old_pm_s  [64];
    logic [PM_W-1:0] m0_s      [64];
    logic [PM_W-1:0] m1_s      [64];
    logic [PM_W-1:0] new_pm_s  [64];
    logic [PM_W-1:0] norm_pm_s [64];
    logic [63:0]     dec_s;
    logic            all_msb_s;
    logic [5:0]      best_idx_s;
    logic [PM_W-1:0] best_val_s;
    logic            accept_s;

    assign in_ready = !dec_valid | dec_ready;
    assign accept_s = in_valid & in_ready;

    // Old metrics for this beat: a frame start substitutes the initial set.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            if (in_sof) begin
                old_pm_s[i] = (i == 0) ? ZERO_PM_V : INIT_PM_V;
            end else begin
                old_pm_s[i] = pm_r[i];
            end
        end
    end

    // Add-compare-select per next state; ties keep the even predecessor.
    always_comb begin
        dec_s     = 64'd0;
        all_msb_s = 1'b1;
        for (int n = 0; n < 64; n++) begin
            m0_s[n] = old_pm_s[{n[4:0], 1'b0}]
                    + {{(PM_W-2){1'b0}}, branch_metric({n[5], n[4:0], 1'b0}, rx_pair)};
            m1_s[n] = old_pm_s[{n[4:0], 1'b1}]
                    + {{(PM_W-2){1'b0}}, branch_metric({n[5], n[4:0], 1'b1}, rx_pair)};
            if (m1_s[n] < m0_s[n]) begin
                new_pm_s[n] = m1_s[n];
                dec_s[n]    = 1'b1;
            end else begin
                new_pm_s[n] = m0_s[n];
                dec_s[n]    = 1'b0;
            end
            all_msb_s = all_msb_s & new_pm_s[n][PM_W-1];
        end
    end

    // Drop the common top bit once every metric has crossed half range.
    always_comb begin
        for (int n = 0; n < 64; n++) begin
            norm_pm_s[n] = new_pm_s[n];
            if (all_msb_s) begin
                norm_pm_s[n][PM_W-1] = 1'b0;
            end else begin
                norm_pm_s[n][PM_W-1] = new_pm_s[n][PM_W-1];
            end
        end
    end

    // Minimum search; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx_s = 6'd0;
        best_val_s = norm_pm_s[0];
        for (int i = 1; i < 64; i++) begin
            if (norm_pm_s[i] < best_val_s) begin
                best_idx_s = i[5:0];
                best_val_s = norm_pm_s[i];
            end else begin
                best_val_s = best_val_s;
            end
        end
    end

    // Metric store and single-entry output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                pm_r[i] <= (i == 0) ? ZERO_PM_V : INIT_PM_V;
            end
            dec_valid  <= 1'b0;
            dec_bits   <= 64'd0;
            best_state <= 6'd0;
            best_pm    <= ZERO_PM_V;
            norm_pulse <= 1'b0;
        end else if (accept_s) begin
            for (int i = 0; i < 64; i++) begin
                pm_r[i] <= norm_pm_s[i];
            end
            dec_valid  <= 1'b1;
            dec_bits   <= dec_s;
            best_state <= best_idx_s;
            best_pm    <= best_val_s;
            norm_pulse <= all_msb_s;
        end else if (dec_valid & dec_ready) begin
            dec_valid <= 1'b0;
        end else begin
            dec_valid <= dec_valid;
        end
    end

endmodule

// File: tb/tb_acs_pm_array64.sv
// Randomised bench for acs_pm_array64 against an integer-metric Viterbi model.
module tb_acs_pm_array64;
    localparam int         PM_W    = 8;
    localparam int         INIT_PM = 64;
    localparam logic [6:0] TG0     = 7'o171;
    localparam logic [6:0] TG1     = 7'o133;
    localparam int         HALF    = 1 << (PM_W - 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sof = 1'b0;
    logic [1:0]      rx_pair = 2'b00;
    logic            dec_valid;
    logic            dec_ready = 1'b1;
    logic [63:0]     dec_bits;
    logic [5:0]      best_state;
    logic [PM_W-1:0] best_pm;
    logic            norm_pulse;

    acs_pm_array64 #(.PM_W(PM_W), .INIT_PM(INIT_PM), .G0(TG0), .G1(TG1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .rx_pair(rx_pair), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_bits(dec_bits), .best_state(best_state),
        .best_pm(best_pm), .norm_pulse(norm_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: true metrics as integers, expected output register contents.
    int          mpm [64];
    logic        exp_valid = 1'b0;
    logic [63:0] exp_bits = 64'd0;
    int          exp_best = 0;
    int          exp_bpm = 0;
    logic        exp_norm = 1'b0;
    int          norm_seen = 0;
    logic        last_in_ready;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bm(input int u, input int p, input logic [1:0] rx);
        logic [6:0] r;
        logic c0, c1;
        r  = 7'(u * 64 + p);
        c0 = ^(r & TG0);
        c1 = ^(r & TG1);
        return ((rx[1] != c0) ? 1 : 0) + ((rx[0] != c1) ? 1 : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mpm[i] = (i == 0) ? 0 : INIT_PM;
        exp_valid = 1'b0; exp_bits = 64'd0; exp_best = 0; exp_bpm = 0; exp_norm = 1'b0;
    endtask

    task automatic model_step(input logic sof, input logic [1:0] rx);
        int old [64];
        int nw  [64];
        int m0, m1, p0, mn;
        for (int i = 0; i < 64; i++) old[i] = sof ? ((i == 0) ? 0 : INIT_PM) : mpm[i];
        for (int n = 0; n < 64; n++) begin
            p0 = (n % 32) * 2;
            m0 = old[p0] + bm(n / 32, p0, rx);
            m1 = old[p0 + 1] + bm(n / 32, p0 + 1, rx);
            exp_bits[n] = (m1 < m0);
            nw[n] = (m1 < m0) ? m1 : m0;
        end
        mn = nw[0];
        for (int n = 1; n < 64; n++) if (nw[n] < mn) mn = nw[n];
        exp_norm = (mn >= HALF);
        if (exp_norm) norm_seen++;
        exp_best = 0;
        for (int n = 0; n < 64; n++) begin
            mpm[n] = exp_norm ? nw[n] - HALF : nw[n];
            if (mpm[n] < mpm[exp_best]) exp_best = n;
        end
        exp_bpm = mpm[exp_best];
        exp_valid = 1'b1;
    endtask

    // Drive one cycle of inputs, check in_ready, advance the model at the edge.
    task automatic step(input logic v, input logic sof, input logic [1:0] rx, input logic rdy);
        logic acc;
        @(negedge clk);
        #2;
        in_valid = v; in_sof = sof; rx_pair = rx; dec_ready = rdy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!exp_valid || rdy));
        last_in_ready = in_ready;
        acc = v && (!exp_valid || rdy);
        @(posedge clk);
        if (acc) model_step(sof, rx);
        else if (exp_valid && rdy) exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(dec_valid), 64'd0);
        chk("rst_bits", dec_bits, 64'd0);
        chk("rst_best", 64'({best_state, best_pm, norm_pulse}), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    // Cycle-by-cycle comparison of the output register against the model.
    always @(negedge clk) begin
        chk("dec_valid", 64'(dec_valid), 64'(exp_valid));
        chk("dec_bits", dec_bits, exp_bits);
        chk("best_state", 64'(best_state), 64'(exp_best));
        chk("best_pm", 64'(best_pm), 64'(exp_bpm));
        chk("norm_pulse", 64'(norm_pulse), 64'(exp_norm));
    end

    initial begin
        logic [5:0] es;
        logic [1:0] rx;
        logic       u;
        int         errs, accs;
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        // Frame start with clean zero symbols.
        step(1'b1, 1'b1, 2'b00, 1'b1);
        #1;
        chk("s1_valid", 64'(dec_valid), 64'd1);
        chk("s1_bit0", 64'(dec_bits[0]), 64'd0);
        chk("s1_best", 64'(best_state), 64'd0);
        chk("s1_pm", 64'(best_pm), 64'd0);
        chk("s1_model_best", 64'(exp_best), 64'd0);

        // Input 1 from state 0 then input 0 from state 32 (symbols 11 then 10).
        do_reset();
        step(1'b1, 1'b1, 2'b11, 1'b1);
        #1;
        chk("s2a_best", 64'(best_state), 64'd32);
        chk("s2a_pm", 64'(best_pm), 64'd0);
        chk("s2a_model", 64'(exp_best), 64'd32);
        step(1'b1, 1'b0, 2'b10, 1'b1);
        #1;
        chk("s2b_best", 64'(best_state), 64'd16);
        chk("s2b_pm", 64'(best_pm), 64'd0);
        chk("s2b_model_pm", 64'(exp_bpm), 64'd0);

        // Encoded stream with one flipped symbol every 20 beats.
        es = 6'd0;
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            u  = 1'($urandom_range(0, 1));
            rx = {^({u, es} & TG0), ^({u, es} & TG1)};
            if (k % 20 == 19) begin
                rx = rx ^ ((k % 40 == 19) ? 2'b10 : 2'b01);
                errs++;
            end
            step(1'b1, (k == 0), rx, 1'b1);
            es = {u, es[5:1]};
            #1;
            checks++;
            if (!(int'(best_pm) <= errs)) begin
                failures++;
                $display("FAIL s3_pm_bound: got %0d expected <= %0d", best_pm, errs);
            end
        end

        // Random symbols with random valid/ready to drive metrics through normalisation.
        norm_seen = 0;
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 3) != 0), (k == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end
        checks++;
        if (norm_seen < 1) begin
            failures++;
            $display("FAIL s4_norm: got %0d normalisations expected >= 1", norm_seen);
        end

        // Back-pressure: only one beat may enter while the output is held.
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        accs = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            if (last_in_ready) accs++;
        end
        chk("s5_accepts", 64'(accs), 64'd1);
        chk("s5_stalled", 64'(last_in_ready), 64'd0);
        step(1'b1, 1'b0, 2'b01, 1'b1);
        chk("s5_resume", 64'(last_in_ready), 64'd1);

        // Mid-frame reset with a valid output pending.
        step(1'b1, 1'b0, 2'b11, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 2'b00, 1'b1);
        #1;
        chk("s6_valid", 64'(dec_valid), 64'd1);
        chk("s6_bit0", 64'(dec_bits[0]), 64'd0);
        chk("s6_best", 64'(best_state), 64'd0);
        chk("s6_pm", 64'(best_pm), 64'd0);
        step(1'b0, 1'b0, 2'b00, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
